// File: rtl/wb_commit_pkg.sv
// Shared widths and constants for the write-back commit slice.
package wb_commit_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;

    localparam logic [RegAddrBus-1:0] NOPRegAddr = 5'd0;
    localparam logic [RegBus-1:0]     ZeroWord   = 32'h0000_0000;

    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;
    localparam logic ReadEnable   = 1'b1;
    localparam logic ReadDisable  = 1'b0;

    // A GPR write only counts as architectural when it targets a real register.
    function automatic logic gpr_commits(input logic wreg, input logic [RegAddrBus-1:0] wd);
        return (wreg == WriteEnable) && (wd != NOPRegAddr);
    endfunction

endpackage

// File: rtl/wb_commit_if.sv
// Write-back bundle, read ports and architectural-state outputs of wb_commit.
interface wb_commit_if #(parameter int CNT_W = 32);
    import wb_commit_pkg::*;

    logic [RegAddrBus-1:0] wb_wd;
    logic                  wb_wreg;
    logic [RegBus-1:0]     wb_wdata;
    logic [RegBus-1:0]     wb_hi;
    logic [RegBus-1:0]     wb_lo;
    logic                  wb_whilo;
    logic                  wb_LLbit_we;
    logic                  wb_LLbit_value;
    logic                  flush;

    logic                  re1;
    logic                  re2;
    logic [RegAddrBus-1:0] raddr1;
    logic [RegAddrBus-1:0] raddr2;
    logic [RegBus-1:0]     rdata1;
    logic [RegBus-1:0]     rdata2;

    logic [RegBus-1:0]     hi_o;
    logic [RegBus-1:0]     lo_o;
    logic                  LLbit_o;
    logic [CNT_W-1:0]      commit_cnt;

    // Pipeline side: presents the WB bundle and read requests.
    modport master (
        output wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo, wb_whilo,
               wb_LLbit_we, wb_LLbit_value, flush,
               re1, re2, raddr1, raddr2,
        input  rdata1, rdata2, hi_o, lo_o, LLbit_o, commit_cnt
    );

    // Commit block side: owns the architectural state.
    modport slave (
        input  wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo, wb_whilo,
               wb_LLbit_we, wb_LLbit_value, flush,
               re1, re2, raddr1, raddr2,
        output rdata1, rdata2, hi_o, lo_o, LLbit_o, commit_cnt
    );

endinterface

// File: rtl/wb_commit_regfile.sv
// General register file: one write port, two bypassed combinational read ports.
module regfile
    import wb_commit_pkg::*;
#(
    parameter int REG_NUM = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [RegAddrBus-1:0] waddr,
    input  logic [RegBus-1:0]     wdata,
    input  logic                  re1,
    input  logic [RegAddrBus-1:0] raddr1,
    output logic [RegBus-1:0]     rdata1,
    input  logic                  re2,
    input  logic [RegAddrBus-1:0] raddr2,
    output logic [RegBus-1:0]     rdata2
);

    logic [RegBus-1:0] regs [REG_NUM];

    // Store committed writes; register 0 is never written so it stays zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= ZeroWord;
            end
        end else if (gpr_commits(we, waddr)) begin
            regs[waddr] <= wdata;
        end
    end

    // Port 1: zero when idle or addressing r0, otherwise forward the in-flight write.
    always_comb begin
        rdata1 = ZeroWord;
        if (!rst && (re1 == ReadEnable) && (raddr1 != NOPRegAddr)) begin
            if ((we == WriteEnable) && (raddr1 == waddr)) begin
                rdata1 = wdata;
            end else begin
                rdata1 = regs[raddr1];
            end
        end
    end

    // Port 2: identical behaviour, independent of port 1.
    always_comb begin
        rdata2 = ZeroWord;
        if (!rst && (re2 == ReadEnable) && (raddr2 != NOPRegAddr)) begin
            if ((we == WriteEnable) && (raddr2 == waddr)) begin
                rdata2 = wdata;
            end else begin
                rdata2 = regs[raddr2];
            end
        end
    end

endmodule

// File: rtl/wb_commit.sv
// Write-back commit: GPRs, HI/LO, LL/SC link bit and a committed-write counter.
module wb_commit
    import wb_commit_pkg::*;
#(
    parameter int REG_NUM = 32,
    parameter int CNT_W   = 32
) (
    input  logic        clk,
    input  logic        rst,
    wb_commit_if.slave  bus
);

    logic [RegBus-1:0] hi_q;
    logic [RegBus-1:0] lo_q;
    logic              llbit_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              gpr_commit;
    logic              any_commit;

    regfile #(
        .REG_NUM (REG_NUM)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (bus.wb_wreg),
        .waddr  (bus.wb_wd),
        .wdata  (bus.wb_wdata),
        .re1    (bus.re1),
        .raddr1 (bus.raddr1),
        .rdata1 (bus.rdata1),
        .re2    (bus.re2),
        .raddr2 (bus.raddr2),
        .rdata2 (bus.rdata2)
    );

    // HI and LO are always written as a pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= ZeroWord;
            lo_q <= ZeroWord;
        end else if (bus.wb_whilo == WriteEnable) begin
            hi_q <= bus.wb_hi;
            lo_q <= bus.wb_lo;
        end
    end

    // HI/LO readers see the value being written this cycle.
    always_comb begin
        bus.hi_o = ZeroWord;
        bus.lo_o = ZeroWord;
        if (!rst) begin
            if (bus.wb_whilo == WriteEnable) begin
                bus.hi_o = bus.wb_hi;
                bus.lo_o = bus.wb_lo;
            end else begin
                bus.hi_o = hi_q;
                bus.lo_o = lo_q;
            end
        end
    end

    // An exception flush breaks any LL/SC reservation, even against a same-cycle LL.
    always_ff @(posedge clk) begin
        if (rst) begin
            llbit_q <= 1'b0;
        end else if (bus.flush) begin
            llbit_q <= 1'b0;
        end else if (bus.wb_LLbit_we == WriteEnable) begin
            llbit_q <= bus.wb_LLbit_value;
        end
    end

    // LLbit readers see the effective value, with flush taking priority.
    always_comb begin
        bus.LLbit_o = 1'b0;
        if (!rst && !bus.flush) begin
            if (bus.wb_LLbit_we == WriteEnable) begin
                bus.LLbit_o = bus.wb_LLbit_value;
            end else begin
                bus.LLbit_o = llbit_q;
            end
        end
    end

    // A cycle commits if it writes a real GPR or the HI/LO pair; both at once count once.
    always_comb begin
        gpr_commit = gpr_commits(bus.wb_wreg, bus.wb_wd);
        any_commit = gpr_commit || (bus.wb_whilo == WriteEnable);
    end

    // Free-running debug counter of committing cycles, wrapping silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (any_commit) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.commit_cnt = cnt_q;

endmodule

// File: tb/tb_wb_commit.sv
// Self-checking bench for wb_commit: directed stimulus plus a per-cycle reference model.
module tb_wb_commit;
    import wb_commit_pkg::*;

    localparam int TB_CNT_W = 4;

    logic clk = 1'b0;
    logic rst;

    int checks_total  = 0;
    int checks_passed = 0;

    // Reference model of architectural state, indexed by register number.
    int unsigned model_regs [32];
    int unsigned model_hi;
    int unsigned model_lo;
    int unsigned model_ll;
    int unsigned model_cnt;

    wb_commit_if #(.CNT_W(TB_CNT_W)) bus ();

    wb_commit #(
        .REG_NUM (32),
        .CNT_W   (TB_CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Set every input for the next cycle shortly after a rising edge.
    task automatic applyStimulus(
        input logic        r,
        input logic        wreg, input logic [4:0] wd, input logic [31:0] wdata,
        input logic        whilo, input logic [31:0] hi, input logic [31:0] lo,
        input logic        llwe, input logic llval, input logic fl,
        input logic        e1, input logic [4:0] a1,
        input logic        e2, input logic [4:0] a2
    );
        @(posedge clk);
        #1;
        rst                = r;
        bus.wb_wreg        = wreg;
        bus.wb_wd          = wd;
        bus.wb_wdata       = wdata;
        bus.wb_whilo       = whilo;
        bus.wb_hi          = hi;
        bus.wb_lo          = lo;
        bus.wb_LLbit_we    = llwe;
        bus.wb_LLbit_value = llval;
        bus.flush          = fl;
        bus.re1            = e1;
        bus.raddr1         = a1;
        bus.re2            = e2;
        bus.raddr2         = a2;
        @(negedge clk);
    endtask

    task automatic idleRead(input logic [4:0] a1, input logic [4:0] a2);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, a1, 1, a2);
    endtask

    function automatic int unsigned expectedRead(input logic e, input logic [4:0] a);
        if (rst || !e || a == 0) return 0;
        if (bus.wb_wreg && a == bus.wb_wd) return bus.wb_wdata;
        return model_regs[a];
    endfunction

    // Compare outputs against the model every cycle, then advance the model across the next edge.
    initial begin
        for (int i = 0; i < 32; i++) model_regs[i] = 0;
        model_hi  = 0;
        model_lo  = 0;
        model_ll  = 0;
        model_cnt = 0;
        forever begin
            @(negedge clk);
            #0;
            checkOutput("model_rdata1", bus.rdata1, expectedRead(bus.re1, bus.raddr1));
            checkOutput("model_rdata2", bus.rdata2, expectedRead(bus.re2, bus.raddr2));
            checkOutput("model_hi", bus.hi_o, rst ? 0 : (bus.wb_whilo ? bus.wb_hi : model_hi));
            checkOutput("model_lo", bus.lo_o, rst ? 0 : (bus.wb_whilo ? bus.wb_lo : model_lo));
            checkOutput("model_llbit", {31'b0, bus.LLbit_o},
                        (rst || bus.flush) ? 0 : (bus.wb_LLbit_we ? bus.wb_LLbit_value : model_ll));
            checkOutput("model_cnt", {28'b0, bus.commit_cnt}, model_cnt % 16);
            if (rst) begin
                for (int i = 0; i < 32; i++) model_regs[i] = 0;
                model_hi  = 0;
                model_lo  = 0;
                model_ll  = 0;
                model_cnt = 0;
            end else begin
                if ((bus.wb_wreg && bus.wb_wd != 0) || bus.wb_whilo) model_cnt = model_cnt + 1;
                if (bus.wb_wreg && bus.wb_wd != 0) model_regs[bus.wb_wd] = bus.wb_wdata;
                if (bus.wb_whilo) begin
                    model_hi = bus.wb_hi;
                    model_lo = bus.wb_lo;
                end
                if (bus.flush) model_ll = 0;
                else if (bus.wb_LLbit_we) model_ll = {31'b0, bus.wb_LLbit_value};
            end
        end
    end

    // Directed sequence with hand-computed literal expectations.
    initial begin
        rst = 1'b1;
        bus.wb_wreg = 0; bus.wb_wd = 0; bus.wb_wdata = 0;
        bus.wb_whilo = 0; bus.wb_hi = 0; bus.wb_lo = 0;
        bus.wb_LLbit_we = 0; bus.wb_LLbit_value = 0; bus.flush = 0;
        bus.re1 = 0; bus.raddr1 = 0; bus.re2 = 0; bus.raddr2 = 0;

        // Reset held two cycles with live writes that must be dropped and outputs forced to 0.
        applyStimulus(1, 1, 9, 32'hAAAA_5555, 1, 32'h99, 32'h88, 1, 1, 0, 1, 9, 1, 9);
        checkOutput("rst_rdata1", bus.rdata1, 32'h0);
        checkOutput("rst_hi", bus.hi_o, 32'h0);
        checkOutput("rst_llbit", {31'b0, bus.LLbit_o}, 32'h0);
        applyStimulus(1, 1, 9, 32'hAAAA_5555, 1, 32'h99, 32'h88, 1, 1, 0, 1, 9, 1, 9);

        idleRead(5, 9);
        checkOutput("reset_read_r5", bus.rdata1, 32'h0);
        checkOutput("reset_dropped_r9", bus.rdata2, 32'h0);
        checkOutput("reset_cnt", {28'b0, bus.commit_cnt}, 32'h0);
        checkOutput("reset_llbit", {31'b0, bus.LLbit_o}, 32'h0);
        checkOutput("reset_lo", bus.lo_o, 32'h0);

        // Write r3 with same-cycle bypass on port 1.
        applyStimulus(0, 1, 3, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 1, 3, 0, 3);
        checkOutput("bypass_r3", bus.rdata1, 32'hDEAD_BEEF);
        checkOutput("re2_off", bus.rdata2, 32'h0);
        idleRead(3, 3);
        checkOutput("stored_r3_p1", bus.rdata1, 32'hDEAD_BEEF);
        checkOutput("stored_r3_p2", bus.rdata2, 32'hDEAD_BEEF);
        checkOutput("cnt_after_r3", {28'b0, bus.commit_cnt}, 32'h1);

        // Register 0 write is discarded and not counted.
        applyStimulus(0, 1, 0, 32'h0000_1234, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        checkOutput("r0_during", bus.rdata1, 32'h0);
        idleRead(0, 3);
        checkOutput("r0_after", bus.rdata1, 32'h0);
        checkOutput("cnt_r0", {28'b0, bus.commit_cnt}, 32'h1);

        // HI/LO plus GPR r4 in one cycle counts once.
        applyStimulus(0, 1, 4, 32'h0000_0044, 1, 32'h11, 32'h22, 0, 0, 0, 1, 3, 1, 4);
        checkOutput("hi_bypass", bus.hi_o, 32'h11);
        checkOutput("lo_bypass", bus.lo_o, 32'h22);
        checkOutput("r4_bypass_p2", bus.rdata2, 32'h44);
        idleRead(4, 3);
        checkOutput("hi_stored", bus.hi_o, 32'h11);
        checkOutput("lo_stored", bus.lo_o, 32'h22);
        checkOutput("cnt_hilo", {28'b0, bus.commit_cnt}, 32'h2);

        // LL sets the link bit, a flush beats a simultaneous LL, GPR r7 still commits.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 4, 0, 0);
        checkOutput("ll_set_bypass", {31'b0, bus.LLbit_o}, 32'h1);
        idleRead(4, 0);
        checkOutput("ll_set_stored", {31'b0, bus.LLbit_o}, 32'h1);
        applyStimulus(0, 1, 7, 32'h0000_0077, 0, 0, 0, 1, 1, 1, 1, 7, 0, 0);
        checkOutput("ll_flush_now", {31'b0, bus.LLbit_o}, 32'h0);
        checkOutput("flush_r7_bypass", bus.rdata1, 32'h77);
        idleRead(7, 3);
        checkOutput("ll_flush_after", {31'b0, bus.LLbit_o}, 32'h0);
        checkOutput("flush_r7_stored", bus.rdata1, 32'h77);
        checkOutput("cnt_flush", {28'b0, bus.commit_cnt}, 32'h3);

        // A bubble changes nothing; a disabled port reads 0.
        applyStimulus(0, 0, 3, 32'hFFFF_FFFF, 0, 32'h5, 32'h6, 0, 1, 0, 0, 3, 1, 3);
        checkOutput("re1_off", bus.rdata1, 32'h0);
        checkOutput("bubble_r3", bus.rdata2, 32'hDEAD_BEEF);
        checkOutput("bubble_hi", bus.hi_o, 32'h11);

        // Partial count, reset mid-stream, then 16 writes wrap the 4-bit counter to 0.
        applyStimulus(0, 1, 8, 32'h8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 9, 32'h9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idleRead(9, 3);
        checkOutput("midrst_dropped_r9", bus.rdata1, 32'h0);
        checkOutput("midrst_cleared_r3", bus.rdata2, 32'h0);
        checkOutput("midrst_cnt", {28'b0, bus.commit_cnt}, 32'h0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 1, 5'(i + 1), 32'h100 + 32'(i), 0, 0, 0, 0, 0, 0, 1, 5'(i + 1), 1, 5'(i));
        end
        idleRead(16, 1);
        checkOutput("wrap_cnt", {28'b0, bus.commit_cnt}, 32'h0);
        checkOutput("wrap_r16", bus.rdata1, 32'h10F);
        checkOutput("wrap_r1", bus.rdata2, 32'h100);
        applyStimulus(0, 1, 2, 32'h2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idleRead(2, 0);
        checkOutput("after_wrap_cnt", {28'b0, bus.commit_cnt}, 32'h1);

        idleRead(0, 0);
        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/wb_commit.md
# wb_commit

Write-back commit block at the far end of the MEM/WB pipeline register. It consumes the registered write-back bundle and holds all architectural state it targets: the 32x32 general register file, HI/LO, and the LL/SC link bit. It serves ID-stage operand reads and MEM/EX-stage HI/LO and LLbit reads, each with same-cycle write-through bypass, and counts committed writes for debug.

## Interface
Parameters:
- REG_NUM, 32, number of general registers; register 0 hard-wired to zero
- CNT_W, 32, width of the commit counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- wb_wd  in  5  destination register address
- wb_wreg  in  1  GPR write enable
- wb_wdata  in  32  GPR write data
- wb_hi  in  32  HI write data
- wb_lo  in  32  LO write data
- wb_whilo  in  1  HI/LO write enable
- wb_LLbit_we  in  1  LLbit write enable
- wb_LLbit_value  in  1  LLbit write value
- flush  in  1  exception/eret flush from ctrl; clears LLbit
- re1, re2  in  1  read-port enables
- raddr1, raddr2  in  5  read-port addresses
- rdata1, rdata2  out  32  read data, combinational
- hi_o, lo_o  out  32  current HI/LO, bypassed
- LLbit_o  out  1  current LLbit, bypassed
- commit_cnt  out  CNT_W  committed-write counter

## Operation
- GPR write: at posedge, if wb_wreg=1 and wb_wd≠0, regs[wb_wd] ← wb_wdata. Writes to register 0 are discarded.
- GPR read, port n:
  - 0 if rst=1, re_n=0, or raddr_n=0.
  - Otherwise wb_wdata if wb_wreg=1 and raddr_n=wb_wd (bypass).
  - Otherwise regs[raddr_n].
  - Both ports are independent and may hit the same address.
- HI/LO: at posedge, if wb_whilo=1, HI ← wb_hi and LO ← wb_lo. Both are always written together.
  - hi_o = wb_whilo ? wb_hi : HI; lo_o likewise.
  - Both outputs are 0 while rst=1.
- LLbit: at posedge, if flush=1, LLbit ← 0; else if wb_LLbit_we=1, LLbit ← wb_LLbit_value.
  - LLbit_o = 0 if rst or flush; else wb_LLbit_we ? wb_LLbit_value : LLbit.
  - Flush beats a simultaneous LLbit write.
- Flush does not block the GPR or HI/LO write of the instruction currently in WB. That instruction has already passed the commit point.
- commit_cnt: increments by 1 at posedge when (wb_wreg=1 and wb_wd≠0) or wb_whilo=1.
  - A cycle with both conditions counts once.
  - Wraps from 2^CNT_W−1 to 0 without a flag.
- Bubbles from a WB stall arrive with all enables 0 and change no state.

## Timing
- Reset (rst=1 at a posedge) clears all GPRs, HI, LO, LLbit and commit_cnt to 0.
- While rst is held, every combinational output reads 0 regardless of other inputs.
- Reset mid-stream: any write presented in the reset cycle is dropped.
- Write latency: a write is visible in storage one cycle after it is presented.
- Bypass makes the write value visible on the read outputs in the same cycle, so no read-after-write hazard exists between WB and ID.
- Read ports, hi_o, lo_o and LLbit_o are purely combinational from inputs plus state; there are no registered outputs except commit_cnt.
- The block has no handshake, no backpressure and never stalls.

## Structure
- Bus widths (RegBus, RegAddrBus), NOPRegAddr, ZeroWord, and the enable/disable and read/write macros come from the shared defines header.
- The block adds no new constants.
- Sub-module: `regfile`, holding the GPR array, write logic and the two bypassed read ports.
- HI/LO, LLbit and the counter stay in the top level, about 40 lines each.

## Test plan
- Reset then read: rst for 2 cycles, then re1=1, raddr1=5 → rdata1=0. commit_cnt=0, LLbit_o=0.
- Write/bypass: wb_wreg=1, wb_wd=3, wb_wdata=0xDEADBEEF with re1=1, raddr1=3 in the same cycle → rdata1=0xDEADBEEF combinationally. Next cycle, with wb_wreg=0 → rdata1 still 0xDEADBEEF and commit_cnt=1.
- Register 0: wb_wreg=1, wb_wd=0, wb_wdata=0x1234 → rdata1 for raddr1=0 stays 0, both during and after the write. commit_cnt is unchanged.
- HI/LO: wb_whilo=1, wb_hi=0x11, wb_lo=0x22 → hi_o=0x11 and lo_o=0x22 in the same cycle and all subsequent cycles. With wb_wreg=1, wb_wd=4 also asserted in that cycle, commit_cnt increments by exactly 1.
- LLbit versus flush:
  - wb_LLbit_we=1, value=1 → LLbit_o=1 and stays 1 after.
  - Next, flush=1 with wb_LLbit_we=1, value=1 → LLbit_o=0 that cycle and 0 after.
  - A GPR write to register 7 in the flush cycle still commits.
- Counter wrap: with CNT_W=4, perform 16 GPR writes → commit_cnt=0. A preceding rst clears any partial count.
